// File: rtl/usb_rx_pkg.sv
// Shared types and constants for the USB full-speed receive-path controller.
//   rx_ctrl_state_t : packet sequencer states (3-bit encoding)
//   *_DEFAULT       : default timing and SYNC values used by the modules
//   phase_width()   : width of the in-bit phase counter for a given bit period
package usb_rx_pkg;

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        SYNC_RCV = 3'd1,
        DATA_RCV = 3'd2,
        WRITE    = 3'd3,
        EOP_WAIT = 3'd4,
        ERR_EOP  = 3'd5,
        ERR_IDLE = 3'd6
    } rx_ctrl_state_t;

    localparam int unsigned CLKS_PER_BIT_DEFAULT = 8;
    localparam int unsigned SAMPLE_PHASE_DEFAULT = 3;
    localparam logic [7:0]  SYNC_BYTE_DEFAULT    = 8'h80;

    function automatic int unsigned phase_width(input int unsigned clks_per_bit);
        return (clks_per_bit > 1) ? $clog2(clks_per_bit) : 1;
    endfunction

    localparam int unsigned PHASE_W_DEFAULT = phase_width(CLKS_PER_BIT_DEFAULT);

endpackage

// File: rtl/usb_bit_timer.sv
// Bit-sampling timer for the USB receive path.
//   clk, rst       : clock, synchronous active-high reset
//   enable         : phase/bit counters run (cleared to 0 when low)
//   sample_en      : sampling allowed in the current state
//   d_edge         : line transition pulse, re-aligns the phase counter
//   eop            : SE0 condition, suppresses sampling
//   sample_point   : phase is at the sampling instant (regardless of eop)
//   byte_aligned   : no bits of a partial byte have been shifted yet
//   shift_enable   : combinational strobe, shift register takes one bit
//   byte_received  : registered strobe, one cycle after the 8th shift
module usb_bit_timer
    import usb_rx_pkg::*;
#(
    parameter int unsigned CLKS_PER_BIT = CLKS_PER_BIT_DEFAULT,
    parameter int unsigned SAMPLE_PHASE = SAMPLE_PHASE_DEFAULT
) (
    input  logic clk,
    input  logic rst,
    input  logic enable,
    input  logic sample_en,
    input  logic d_edge,
    input  logic eop,
    output logic sample_point,
    output logic byte_aligned,
    output logic shift_enable,
    output logic byte_received
);

    localparam int unsigned PHASE_W = phase_width(CLKS_PER_BIT);
    localparam logic [PHASE_W-1:0] PHASE_LAST   = PHASE_W'(CLKS_PER_BIT - 1);
    localparam logic [PHASE_W-1:0] PHASE_SAMPLE = PHASE_W'(SAMPLE_PHASE);

    logic [PHASE_W-1:0] phase_reg, phase_next;
    logic [2:0]         bit_cnt_reg, bit_cnt_next;
    logic               byte_received_reg, byte_received_next;

    assign sample_point  = sample_en && (phase_reg == PHASE_SAMPLE);
    assign shift_enable  = sample_point && !eop;
    assign byte_aligned  = (bit_cnt_reg == 3'd0);
    assign byte_received = byte_received_reg;

    always_comb begin
        phase_next         = '0;
        bit_cnt_next       = 3'd0;
        byte_received_next = 1'b0;
        if (enable) begin
            // A line edge marks the start of a bit cell: restart the phase there.
            if (!d_edge) begin
                phase_next = (phase_reg == PHASE_LAST) ? '0 : phase_reg + PHASE_W'(1);
            end
            bit_cnt_next = bit_cnt_reg;
            if (shift_enable) begin
                // 3-bit counter wraps 7 -> 0 on the 8th shift by itself.
                bit_cnt_next       = bit_cnt_reg + 3'd1;
                byte_received_next = (bit_cnt_reg == 3'd7);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            phase_reg         <= '0;
            bit_cnt_reg       <= 3'd0;
            byte_received_reg <= 1'b0;
        end else begin
            phase_reg         <= phase_next;
            bit_cnt_reg       <= bit_cnt_next;
            byte_received_reg <= byte_received_next;
        end
    end

endmodule

// File: rtl/usb_rx_ctrl.sv
// Receive-path packet sequencer for the USB full-speed receiver.
//   clk, rst      : clock, synchronous active-high reset
//   d_edge        : one-cycle pulse on each D+ transition
//   eop           : synchronized SE0 condition
//   rcv_data      : parallel contents of the external receive shift register
//   shift_enable  : shift register samples a bit (combinational)
//   byte_received : 8 bits have been shifted (registered)
//   rcving        : packet reception in progress
//   w_enable      : one-cycle FIFO write strobe for rcv_data
//   r_error       : packet error, held until the next packet starts
module usb_rx_ctrl
    import usb_rx_pkg::*;
#(
    parameter int unsigned CLKS_PER_BIT = CLKS_PER_BIT_DEFAULT,
    parameter int unsigned SAMPLE_PHASE = SAMPLE_PHASE_DEFAULT,
    parameter logic [7:0]  SYNC_BYTE    = SYNC_BYTE_DEFAULT
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       d_edge,
    input  logic       eop,
    input  logic [7:0] rcv_data,
    output logic       shift_enable,
    output logic       byte_received,
    output logic       rcving,
    output logic       w_enable,
    output logic       r_error
);

    rx_ctrl_state_t state_reg, state_next;
    logic           eop_seen_reg, eop_seen_next;
    logic           timer_enable, timer_sample_en;
    logic           sample_point, byte_aligned;

    // Sampling only happens while bits are expected; the phase keeps running
    // through WRITE so the bit following a completed byte is not lost.
    assign timer_sample_en = (state_reg == SYNC_RCV) || (state_reg == DATA_RCV);
    assign timer_enable    = timer_sample_en || (state_reg == WRITE);

    usb_bit_timer #(
        .CLKS_PER_BIT (CLKS_PER_BIT),
        .SAMPLE_PHASE (SAMPLE_PHASE)
    ) u_bit_timer (
        .clk           (clk),
        .rst           (rst),
        .enable        (timer_enable),
        .sample_en     (timer_sample_en),
        .d_edge        (d_edge),
        .eop           (eop),
        .sample_point  (sample_point),
        .byte_aligned  (byte_aligned),
        .shift_enable  (shift_enable),
        .byte_received (byte_received)
    );

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE: begin
                if (d_edge) state_next = SYNC_RCV;
            end
            SYNC_RCV: begin
                if (byte_received) begin
                    state_next = (rcv_data == SYNC_BYTE) ? DATA_RCV : ERR_EOP;
                end else if (eop && sample_point) begin
                    state_next = ERR_EOP;
                end
            end
            DATA_RCV: begin
                // A completed byte takes priority; a coincident EOP is seen
                // again at the next sample point, by then byte-aligned.
                if (byte_received) begin
                    state_next = WRITE;
                end else if (eop && sample_point) begin
                    state_next = byte_aligned ? EOP_WAIT : ERR_EOP;
                end
            end
            WRITE: begin
                state_next = DATA_RCV;
            end
            EOP_WAIT: begin
                if (!eop) state_next = IDLE;
            end
            ERR_EOP: begin
                if (eop_seen_reg && !eop) state_next = ERR_IDLE;
            end
            ERR_IDLE: begin
                if (d_edge) state_next = SYNC_RCV;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // ERR_EOP may be entered before the SE0 arrives (bad SYNC), so remember
    // whether eop has been high since entry, including the entry cycle.
    assign eop_seen_next = (state_next == ERR_EOP) && (eop_seen_reg || eop);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg    <= IDLE;
            eop_seen_reg <= 1'b0;
        end else begin
            state_reg    <= state_next;
            eop_seen_reg <= eop_seen_next;
        end
    end

    assign rcving   = (state_reg == SYNC_RCV) || (state_reg == DATA_RCV) ||
                      (state_reg == WRITE)    || (state_reg == EOP_WAIT) ||
                      (state_reg == ERR_EOP);
    assign w_enable = (state_reg == WRITE);
    assign r_error  = (state_reg == ERR_EOP) || (state_reg == ERR_IDLE);

endmodule

// File: tb/tb_usb_rx_ctrl.sv
// Self-checking bench for usb_rx_ctrl. The bench plays the line side and the
// external LSB-first shift register; a packet-level model predicts the FIFO
// writes and final error flag, and a monitor compares them as the DUT emits.
module tb_usb_rx_ctrl;

    localparam int CLKS = 8;
    typedef logic [7:0] bq_t[$];

    logic       tb_clk = 1'b0;
    logic       rst, d_edge, eop;
    logic [7:0] rcv_data;
    logic       shift_enable, byte_received, rcving, w_enable, r_error;

    int   n_checks = 0;
    int   n_fail   = 0;
    logic [7:0] exp_data_q[$];
    logic exp_err_q[$];
    logic bit_q[$];
    bq_t  pkt;
    int   shift_cnt = 0;
    bit   mon_en = 1'b0;
    logic prev_rcving = 1'b0;
    logic last_err = 1'b0;

    always #5 tb_clk = ~tb_clk;

    usb_rx_ctrl dut (
        .clk           (tb_clk),
        .rst           (rst),
        .d_edge        (d_edge),
        .eop           (eop),
        .rcv_data      (rcv_data),
        .shift_enable  (shift_enable),
        .byte_received (byte_received),
        .rcving        (rcving),
        .w_enable      (w_enable),
        .r_error       (r_error)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // One clock; acts as the external shift register (new bit enters at MSB).
    task automatic step();
        @(negedge tb_clk);
        if (shift_enable === 1'b1) begin
            logic b;
            b = 1'b0;
            if (bit_q.size() > 0) b = bit_q.pop_front();
            rcv_data = {b, rcv_data[7:1]};
            shift_cnt++;
        end
    endtask

    // Pulse d_edge now; the next sample must land exactly 4 cycles later.
    task automatic pulse_edge_check(input string tag, input bit start);
        d_edge = 1'b1;
        step();
        d_edge = 1'b0;
        if (start) begin
            check({tag, " rcving_start"}, rcving, 1'b1);
            check({tag, " r_error_clear"}, r_error, 1'b0);
        end
        check({tag, " lat1"}, shift_enable, 1'b0);
        step();
        check({tag, " lat2"}, shift_enable, 1'b0);
        step();
        check({tag, " lat3"}, shift_enable, 1'b0);
        step();
        check({tag, " lat4"}, shift_enable, 1'b1);
    endtask

    task automatic wait_shifts(input string tag, input int n, input bit rand_edges);
        int guard;
        guard = 0;
        while (shift_cnt < n) begin
            if (guard > 600) begin
                check({tag, " shift_timeout"}, shift_cnt, n);
                break;
            end
            d_edge = rand_edges && ($urandom_range(0, 9) == 0);
            step();
            d_edge = 1'b0;
            guard++;
        end
    endtask

    task automatic make_pkt(input int n, input logic [7:0] b0, input logic [7:0] b1,
                            input logic [7:0] b2);
        pkt.delete();
        if (n > 0) pkt.push_back(b0);
        if (n > 1) pkt.push_back(b1);
        if (n > 2) pkt.push_back(b2);
    endtask

    // Sends pkt plus `extra` trailing bits, then an SE0 of two bit periods.
    task automatic send_packet(input string tag, input int extra, input int eop_delay,
                               input bit rand_edges, input int resync_after,
                               input int abort_at);
        logic bits[$];
        int   target;
        int   n_wr;
        logic err;
        foreach (pkt[i]) for (int j = 0; j < 8; j++) bits.push_back(pkt[i][j]);
        for (int j = 0; j < extra; j++) bits.push_back(1'($urandom_range(0, 1)));
        // Packet-level reference: bad/short SYNC gives an error and no data;
        // otherwise every complete byte after SYNC is written, and trailing
        // bits make the EOP misaligned.
        n_wr = 0;
        if (bits.size() < 8) begin
            target = bits.size();
            err    = 1'b1;
        end else if (pkt[0] != 8'h80) begin
            target = 8;
            err    = 1'b1;
        end else begin
            target = bits.size();
            err    = (bits.size() % 8) != 0;
            for (int i = 1; i < pkt.size(); i++) begin
                exp_data_q.push_back(pkt[i]);
                n_wr++;
            end
        end
        exp_err_q.push_back(err);
        $display("pkt %s: bytes=%0d extra_bits=%0d exp_writes=%0d exp_err=%0b",
                 tag, pkt.size(), extra, n_wr, err);
        bit_q = bits;
        shift_cnt = 0;
        check({tag, " idle_rcving"}, rcving, 1'b0);
        check({tag, " held_r_error"}, r_error, last_err);
        pulse_edge_check(tag, 1'b1);
        if (abort_at > 0) begin
            wait_shifts(tag, abort_at, 1'b0);
            mon_en = 1'b0;
            rst = 1'b1;
            step();
            check({tag, " rst_shift_enable"}, shift_enable, 1'b0);
            check({tag, " rst_byte_received"}, byte_received, 1'b0);
            check({tag, " rst_rcving"}, rcving, 1'b0);
            check({tag, " rst_w_enable"}, w_enable, 1'b0);
            check({tag, " rst_r_error"}, r_error, 1'b0);
            step();
            rst = 1'b0;
            step();
            check({tag, " post_rst_rcving"}, rcving, 1'b0);
            check({tag, " post_rst_shift"}, shift_enable, 1'b0);
            repeat (n_wr) void'(exp_data_q.pop_back());
            void'(exp_err_q.pop_back());
            bit_q.delete();
            last_err = 1'b0;
            mon_en = 1'b1;
            return;
        end
        if (resync_after > 0) begin
            wait_shifts(tag, resync_after, 1'b0);
            repeat (3) step();
            pulse_edge_check({tag, " resync"}, 1'b0);
        end
        wait_shifts(tag, target, rand_edges);
        repeat (eop_delay) step();
        eop = 1'b1;
        repeat (2 * CLKS) step();
        eop = 1'b0;
        check({tag, " rcving_hold"}, rcving, 1'b1);
        step();
        check({tag, " rcving_drop"}, rcving, 1'b0);
        check({tag, " r_error_end"}, r_error, err);
        check({tag, " shift_count"}, shift_cnt, target);
        repeat ($urandom_range(2, 5)) step();
        last_err = err;
    endtask

    // Scoreboard monitor: FIFO writes and end-of-packet error flag.
    always @(negedge tb_clk) begin
        if (mon_en) begin
            if (w_enable === 1'b1) begin
                if (exp_data_q.size() == 0) begin
                    check("w_enable_unexpected", w_enable, 1'b0);
                end else begin
                    check("w_data", rcv_data, exp_data_q.pop_front());
                end
            end
            if (prev_rcving === 1'b1 && rcving === 1'b0) begin
                if (exp_err_q.size() == 0) begin
                    check("pkt_end_unexpected", 32'(exp_err_q.size()), 1);
                end else begin
                    check("pkt_r_error", r_error, exp_err_q.pop_front());
                end
            end
            prev_rcving = rcving;
        end else begin
            prev_rcving = 1'b0;
        end
    end

    initial begin
        rst      = 1'b1;
        d_edge   = 1'b0;
        eop      = 1'b0;
        rcv_data = 8'h00;
        step();
        step();
        check("reset shift_enable", shift_enable, 1'b0);
        check("reset byte_received", byte_received, 1'b0);
        check("reset rcving", rcving, 1'b0);
        check("reset w_enable", w_enable, 1'b0);
        check("reset r_error", r_error, 1'b0);
        rst = 1'b0;
        step();
        mon_en = 1'b1;

        make_pkt(3, 8'h80, 8'hA5, 8'h3C);
        send_packet("good", 0, 2, 1'b0, 0, 0);
        make_pkt(2, 8'h81, 8'h55, 8'h00);
        send_packet("bad_sync", 0, 2, 1'b0, 0, 0);
        make_pkt(1, 8'h80, 8'h00, 8'h00);
        send_packet("misaligned", 5, 2, 1'b0, 0, 0);
        make_pkt(2, 8'h80, 8'h5A, 8'h00);
        send_packet("resync", 0, 2, 1'b0, 11, 0);
        make_pkt(2, 8'h80, 8'hC3, 8'h00);
        send_packet("simultaneous", 0, 1, 1'b0, 0, 0);
        make_pkt(2, 8'h80, 8'h77, 8'h00);
        send_packet("reset_mid", 0, 2, 1'b0, 0, 12);
        make_pkt(2, 8'h80, 8'h11, 8'h00);
        send_packet("after_reset", 0, 3, 1'b1, 0, 0);

        for (int p = 0; p < 14; p++) begin
            int kind;
            int nd;
            int extra;
            logic [7:0] s;
            kind  = $urandom_range(0, 9);
            nd    = $urandom_range(0, 3);
            extra = 0;
            pkt.delete();
            if (kind == 0) begin
                extra = $urandom_range(1, 7);
            end else begin
                s = 8'h80;
                if (kind == 1) begin
                    s = 8'($urandom_range(0, 255));
                    if (s == 8'h80) s = 8'h00;
                end
                pkt.push_back(s);
                for (int i = 0; i < nd; i++) pkt.push_back(8'($urandom_range(0, 255)));
                if (kind == 2 || kind == 3) extra = $urandom_range(1, 7);
            end
            send_packet($sformatf("rand%0d", p), extra, $urandom_range(1, 3), 1'b1, 0, 0);
        end

        step();
        check("writes_outstanding", 32'(exp_data_q.size()), 0);
        check("packets_outstanding", 32'(exp_err_q.size()), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
